// File: rtl/cpu_ram_responder_if.sv
// ---------------------------------------------------------------------------
// cpu_ram_responder_if
// Bus bundle between the CPU/loader side and the RAM responder.
//
// Signals:
//   addr_toRAM    CPU word address
//   data_toRAM    CPU write data
//   wrEn          CPU write enable
//   data_fromRAM  registered read data back to the CPU
//   load_valid    loader byte strobe
//   load_byte     loader byte
//   load_last     marks the final byte of the program image
//   load_ready    responder accepts a loader byte this cycle
//
// Modports:
//   master  the CPU plus the board-level byte source (drives requests)
//   slave   the RAM responder (drives read data and load_ready)
// ---------------------------------------------------------------------------
interface cpu_ram_responder_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] addr_toRAM;
    logic [15:0]       data_toRAM;
    logic              wrEn;
    logic [15:0]       data_fromRAM;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_last;
    logic              load_ready;

    modport master (
        output addr_toRAM,
        output data_toRAM,
        output wrEn,
        output load_valid,
        output load_byte,
        output load_last,
        input  data_fromRAM,
        input  load_ready
    );

    modport slave (
        input  addr_toRAM,
        input  data_toRAM,
        input  wrEn,
        input  load_valid,
        input  load_byte,
        input  load_last,
        output data_fromRAM,
        output load_ready
    );
endinterface

// File: rtl/cpu_ram_responder.sv
// ---------------------------------------------------------------------------
// cpu_ram_responder
// Memory-side responder for the 16-bit accumulator CPU. Owns the RAM array,
// serves CPU reads (1-cycle latency) and writes, and contains a byte-serial
// big-endian program loader that fills the array after reset. The CPU is
// held in reset until the image is in RAM.
//
// Parameters:
//   ADDR_W  CPU address width
//   DEPTH   number of 16-bit words (<= 2**ADDR_W)
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   bus         slave side of cpu_ram_responder_if (CPU + loader signals)
//   cpu_rst     registered reset to the CPU, released after the load
//   load_done   image loaded, CPU running
//   load_count  number of full words written by the loader
//
// States:
//   state   | meaning
//   LOAD_HI | waiting for the high byte of the next image word
//   LOAD_LO | high byte held, waiting for the low byte
//   RUN     | image loaded, RAM serves the CPU port
// ---------------------------------------------------------------------------
module cpu_ram_responder #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic                clk,
    input  logic                rst,
    cpu_ram_responder_if.slave  bus,
    output logic                cpu_rst,
    output logic                load_done,
    output logic [ADDR_W:0]     load_count
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DEPTH_M1 = DEPTH - 1;
    localparam logic [ADDR_W:0] DEPTH_V  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_PTR = DEPTH_M1[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE      = 1;

    localparam logic [1:0] LOAD_HI = 2'd0;
    localparam logic [1:0] LOAD_LO = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [7:0]       hi_byte;
    logic             loading;
    logic             in_run;
    logic             accept;
    logic             cpu_addr_ok;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [15:0]      mem_wdata;
    logic [IDX_W-1:0] cpu_idx;

    logic [15:0] mem [0:DEPTH-1];

    assign loading = (state == LOAD_HI) || (state == LOAD_LO);
    assign in_run  = (state == RUN);

    // Depends only on state and rst so the byte source never sees a
    // combinational path from its own strobe.
    assign bus.load_ready = loading && !rst;
    assign accept         = bus.load_valid && bus.load_ready;

    assign cpu_addr_ok = ({1'b0, bus.addr_toRAM} < DEPTH_V);
    assign cpu_idx     = bus.addr_toRAM[IDX_W-1:0];

    // The loader write pointer is the count of completed words, so
    // load_count doubles as the pointer.
    always_comb begin
        state_next = state;
        case (state)
            LOAD_HI: begin
                if (accept) begin
                    state_next = bus.load_last ? RUN : LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (accept) begin
                    // Stop at the top of the array rather than wrapping.
                    if (bus.load_last || (load_count == LAST_PTR)) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD_HI;
                    end
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = LOAD_HI;
            end
        endcase
    end

    // Single write port shared by loader and CPU; the two never overlap
    // because CPU writes only land in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = load_count[IDX_W-1:0];
        mem_wdata = {hi_byte, bus.load_byte};
        if (!rst) begin
            case (state)
                LOAD_HI: begin
                    // A last-flagged high byte is padded with a zero low byte.
                    if (accept && bus.load_last) begin
                        mem_we    = 1'b1;
                        mem_wdata = {bus.load_byte, 8'h00};
                    end
                end
                LOAD_LO: begin
                    if (accept) begin
                        mem_we = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.wrEn && cpu_addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = cpu_idx;
                        mem_wdata = bus.data_toRAM;
                    end
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // No reset on the array: contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= LOAD_HI;
            load_count       <= '0;
            hi_byte          <= 8'h00;
            bus.data_fromRAM <= 16'h0000;
            cpu_rst          <= 1'b1;
            load_done        <= 1'b0;
        end else begin
            state <= state_next;

            // Released one edge after entering RUN, so the final word is
            // already committed when the CPU starts.
            cpu_rst   <= !in_run;
            load_done <= in_run;

            if ((state == LOAD_HI) && accept) begin
                hi_byte <= bus.load_byte;
            end

            if ((state == LOAD_LO) && accept) begin
                load_count <= load_count + ONE;
            end

            // Nonblocking read alongside the write gives old data on a
            // same-address read-during-write.
            if (in_run && cpu_addr_ok) begin
                bus.data_fromRAM <= mem[cpu_idx];
            end else begin
                bus.data_fromRAM <= 16'h0000;
            end
        end
    end

endmodule
